cic_interpolator: RTL and testbench
===================================

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the input sample width.
REQ-002 The block SHALL have parameter BIT_GROWTH, default 12, giving the internal/output growth bits; OUT_W = WIDTH+BIT_GROWTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port x_n, input, WIDTH bits: signed low-rate input sample.
REQ-006 The block SHALL have port x_valid, input, 1 bit: x_n is valid this cycle.
REQ-007 The block SHALL have port x_ready, output, 1 bit: the block accepts x_n this cycle.
REQ-008 The block SHALL have port Interp_Factor, input, 5 bits: interpolation factor R in {1,2,4,8,16}.
REQ-009 The block SHALL have port y_n, output, OUT_W bits: signed high-rate output, registered.
REQ-010 The block SHALL have port y_valid, output, 1 bit: y_n carries filter output.
REQ-011 The block SHALL have port underflow, output, 1 bit: sticky, no input at a required slot.

Function
REQ-012 Structure SHALL be fixed: N=3 comb stages (M=1) at low rate, then zero-stuffing by R, then 3 integrators at clk rate.
REQ-013 Arithmetic SHALL be two's complement, modulo 2^OUT_W (wrap, never saturate); x_n SHALL be sign-extended to OUT_W.
REQ-014 A phase counter SHALL count 0..R_act-1 every clk and wrap to 0; x_ready SHALL equal (phase==0).
REQ-015 R_act SHALL load from Interp_Factor only when the phase counter wraps to 0 (and at reset release); mid-period changes SHALL NOT take effect early.
REQ-016 Interp_Factor values outside {1,2,4,8,16} SHALL be treated as R_act=1.
REQ-017 Accept SHALL occur at a rising edge where x_valid and x_ready are both 1; at that edge the comb delay registers d1..d3 SHALL update: c1=x-d1, c2=c1-d2, c3=c2-d3, with d1<=x, d2<=c1, d3<=c2.
REQ-018 At phase 0 with x_valid=0, the combs SHALL process a zero sample, and underflow SHALL set and remain 1 until reset.
REQ-019 up_reg SHALL load c3 at every phase-0 edge and 0 at all other edges (zero-stuffing).
REQ-020 Integrators SHALL update every clk: I1<=I1+up_reg, I2<=I2+I1, I3<=I3+I2, with y_n=I3.
REQ-021 Latency SHALL be 3 clk: an impulse accepted at edge k appears on y_n after edge k+3.
REQ-022 y_valid SHALL rise after edge k+3, where k is the first accept, and stay 1 until reset.
REQ-023 DC gain SHALL be R^2: a constant input x settles to y=R^2*x.
REQ-024 x_valid while x_ready=0 SHALL be ignored; the source holds data until accepted.

Reset
REQ-025 While rst_n=0: phase=0, R_act=1, d1..d3=0, up_reg=0, I1..I3=0, y_n=0, y_valid=0, underflow=0; x_ready=1 (phase==0), with no accept while rst_n=0.
REQ-026 Reset asserted mid-operation SHALL clear all state immediately (asynchronously), regardless of phase.

Verification
REQ-027 R=1, accept x=1 at edge 0, then x=0 -> y_n=1 after edge 3 only; 0 otherwise; y_valid rises after edge 3.
REQ-028 R=4, constant x=100 with x_valid=1 -> x_ready high 1 of every 4 cycles; y_n settles to 1600 and holds.
REQ-029 R=16, constant x=-32768 -> y_n settles to -8388608 with no wrap error; underflow stays 0.
REQ-030 R=8, x_valid=0 at one phase-0 slot -> zero inserted, underflow=1 and sticky; output deviates from steady state.
REQ-031 Interp_Factor changed 4->8 mid-period -> x_ready spacing stays 4 until the next wrap, then becomes 8; Interp_Factor=3 -> behaves as R=1.
REQ-032 rst_n pulsed low during steady R=4 operation -> all outputs 0 at once; restart matches REQ-028.

Source files
------------

// File: rtl/cic_interpolator.sv
// Three-stage CIC interpolator: low-rate comb section, zero-stuffing by R, clk-rate integrators.
// R in {1,2,4,8,16} is taken from Interp_Factor only at period boundaries.
module cic_interpolator #(
    parameter int WIDTH      = 16,
    parameter int BIT_GROWTH = 12
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic signed [WIDTH-1:0]            x_n,
    input  logic                               x_valid,
    output logic                               x_ready,
    input  logic [4:0]                         Interp_Factor,
    output logic signed [WIDTH+BIT_GROWTH-1:0] y_n,
    output logic                               y_valid,
    output logic                               underflow
);
    localparam int OUT_W    = WIDTH + BIT_GROWTH;
    localparam int N_STAGES = 3;

    logic [4:0] phase_reg, phase_next;
    logic [4:0] r_act_reg, r_act_next;
    logic [4:0] factor_dec;
    logic [4:0] r_eff;
    logic       first_reg;
    logic       wrap;
    logic       slot;

    logic signed [OUT_W-1:0] sample;
    logic signed [OUT_W-1:0] d_reg    [N_STAGES];
    logic signed [OUT_W-1:0] comb_val [N_STAGES+1];
    logic signed [OUT_W-1:0] up_reg;
    logic signed [OUT_W-1:0] integ_val [N_STAGES+1];

    logic [2:0] vpipe_reg;
    logic       y_valid_reg;
    logic       underflow_reg;

    always_comb begin
        case (Interp_Factor)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: factor_dec = Interp_Factor;
            default:                        factor_dec = 5'd1;
        endcase
    end

    // The first edge after reset release uses the requested factor directly,
    // so the very first period already has the right length.
    assign r_eff      = first_reg ? factor_dec : r_act_reg;
    assign wrap       = (phase_reg == r_eff - 5'd1);
    assign phase_next = wrap ? 5'd0 : phase_reg + 5'd1;
    assign r_act_next = (first_reg || wrap) ? factor_dec : r_act_reg;
    assign slot       = (phase_reg == 5'd0);
    assign x_ready    = slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= 5'd0;
            r_act_reg <= 5'd1;
            first_reg <= 1'b1;
        end else begin
            phase_reg <= phase_next;
            r_act_reg <= r_act_next;
            first_reg <= 1'b0;
        end
    end

    // A missing sample at a slot is processed as zero.
    assign sample = x_valid ? {{BIT_GROWTH{x_n[WIDTH-1]}}, x_n} : '0;

    always_comb begin
        comb_val[0] = sample;
        for (int i = 0; i < N_STAGES; i++) begin
            comb_val[i+1] = comb_val[i] - d_reg[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STAGES; i++) begin
                d_reg[i] <= '0;
            end
            up_reg <= '0;
        end else begin
            if (slot) begin
                for (int i = 0; i < N_STAGES; i++) begin
                    d_reg[i] <= comb_val[i];
                end
            end
            up_reg <= slot ? comb_val[N_STAGES] : '0;
        end
    end

    assign integ_val[0] = up_reg;

    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_integ
        logic signed [OUT_W-1:0] acc_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_reg <= '0;
            end else begin
                acc_reg <= acc_reg + integ_val[gi];
            end
        end

        assign integ_val[gi+1] = acc_reg;
    end

    assign y_n = integ_val[N_STAGES];

    // Valid follows the first accepted sample through the three integrator stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_reg     <= 3'b000;
            y_valid_reg   <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            vpipe_reg   <= {vpipe_reg[1:0], vpipe_reg[0] | (slot & x_valid)};
            y_valid_reg <= vpipe_reg[2];
            if (slot && !x_valid) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign y_valid   = y_valid_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator: impulse tables for R=1/R=2 plus
// sequences for DC gain, underflow, factor changes and asynchronous reset.
module tb_cic_interpolator;
    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] x_n;
    logic               x_valid;
    logic               x_ready;
    logic [4:0]         interp_factor;
    logic signed [27:0] y_n;
    logic               y_valid;
    logic               underflow;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    cic_interpolator #(.WIDTH(16), .BIT_GROWTH(12)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .x_n           (x_n),
        .x_valid       (x_valid),
        .x_ready       (x_ready),
        .Interp_Factor (interp_factor),
        .y_n           (y_n),
        .y_valid       (y_valid),
        .underflow     (underflow)
    );

    typedef struct {
        bit       rst_before;
        bit [4:0] fac;
        int       x;
        bit       xv;
        int       y;
        bit       yv;
        bit       rdy;
    } vec_t;

    vec_t vecs [17];
    int   r2_y [9] = '{0, 0, 0, 1, 3, 3, 1, 0, 0};

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " rst y"}, int'(y_n), 0);
        chk({tag, " rst y_valid"}, int'(y_valid), 0);
        chk({tag, " rst x_ready"}, int'(x_ready), 1);
        chk({tag, " rst underflow"}, int'(underflow), 0);
        #2 rst_n = 1'b1;
    endtask

    task automatic steps_to_ready(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!x_ready && n < max);
    endtask

    task automatic run_r4(input string tag);
        interp_factor = 5'd4;
        x_n           = 16'sd100;
        x_valid       = 1'b1;
        do_reset(tag);
        for (int i = 0; i < 40; i++) begin
            step();
            chk($sformatf("%s ready e%0d", tag, i), int'(x_ready), ((i + 1) % 4 == 0) ? 1 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("%s dc y%0d", tag, i), int'(y_n), 1600);
        end
        chk({tag, " y_valid"}, int'(y_valid), 1);
        chk({tag, " underflow"}, int'(underflow), 0);
    endtask

    initial begin
        int n;
        bit dev;

        rst_n         = 1'b0;
        x_n           = '0;
        x_valid       = 1'b1;
        interp_factor = 5'd1;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{(i == 0), 5'd1, (i == 0) ? 1 : 0, 1'b1, (i == 3) ? 1 : 0, (i >= 3), 1'b1};
        end
        for (int i = 0; i < 9; i++) begin
            vecs[8+i] = '{(i == 0), 5'd2, (i == 0) ? 1 : 0, 1'b1, r2_y[i], (i >= 3), (i % 2 == 1)};
        end

        // Impulse responses: R=1 is a pure 3-cycle delay, R=2 gives 1,3,3,1.
        for (int i = 0; i < 17; i++) begin
            interp_factor = vecs[i].fac;
            x_n           = 16'(vecs[i].x);
            x_valid       = vecs[i].xv;
            if (vecs[i].rst_before) do_reset($sformatf("vec%0d", i));
            step();
            chk($sformatf("vec%0d y", i), int'(y_n), vecs[i].y);
            chk($sformatf("vec%0d y_valid", i), int'(y_valid), int'(vecs[i].yv));
            chk($sformatf("vec%0d x_ready", i), int'(x_ready), int'(vecs[i].rdy));
            chk($sformatf("vec%0d underflow", i), int'(underflow), 0);
        end

        run_r4("r4");

        // Asynchronous reset mid-cycle during steady R=4 operation.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async y", int'(y_n), 0);
        chk("async y_valid", int'(y_valid), 0);
        chk("async x_ready", int'(x_ready), 1);
        chk("async underflow", int'(underflow), 0);
        run_r4("r4 restart");

        // Full-scale negative input at R=16.
        interp_factor = 5'd16;
        x_n           = 16'sh8000;
        x_valid       = 1'b1;
        do_reset("r16");
        repeat (120) step();
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("r16 y%0d", i), int'(y_n), -8388608);
        end
        chk("r16 underflow", int'(underflow), 0);

        // Missed slot at R=8.
        interp_factor = 5'd8;
        x_n           = 16'sd1000;
        x_valid       = 1'b1;
        do_reset("r8");
        repeat (80) step();
        chk("r8 steady y", int'(y_n), 64000);
        chk("r8 underflow before", int'(underflow), 0);
        steps_to_ready(16, n);
        chk("r8 slot found", int'(x_ready), 1);
        x_valid = 1'b0;
        step();
        x_valid = 1'b1;
        chk("r8 underflow set", int'(underflow), 1);
        dev = 1'b0;
        repeat (60) begin
            step();
            if (y_n != 28'sd64000) dev = 1'b1;
        end
        chk("r8 deviation seen", int'(dev), 1);
        chk("r8 underflow sticky", int'(underflow), 1);
        chk("r8 recovered y", int'(y_n), 64000);

        // Factor 4 -> 8 change one cycle into a period.
        interp_factor = 5'd4;
        x_n           = 16'sd100;
        x_valid       = 1'b1;
        do_reset("chg");
        repeat (20) step();
        steps_to_ready(8, n);
        chk("chg align", int'(x_ready), 1);
        step();
        interp_factor = 5'd8;
        steps_to_ready(16, n);
        chk("chg gap old", n, 3);
        steps_to_ready(16, n);
        chk("chg gap new1", n, 8);
        steps_to_ready(16, n);
        chk("chg gap new2", n, 8);

        // Illegal factor 3 behaves as R=1.
        interp_factor = 5'd3;
        x_n           = 16'sd5;
        x_valid       = 1'b1;
        do_reset("f3");
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("f3 ready e%0d", i), int'(x_ready), 1);
        end
        chk("f3 y", int'(y_n), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
